// File: rtl/csr_perf_counters.sv
// csr_perf_counters: mcycle/minstret/HPM counters with mcountinhibit behind a CSR read/RMW port
// Ports:
//   clk, rst_n                - core clock, asynchronous active-low reset
//   csr_en, csr_addr, csr_op  - CSR access in execute (op: 00 read, 01 RW, 10 RS, 11 RC)
//   csr_wdata                 - rs1 value or zero-extended immediate
//   csr_rdata                 - pre-write value of the addressed CSR (0 when idle or unmapped)
//   csr_illegal               - unmapped access or write attempt to a read-only alias
//   retire_valid, stall       - instruction retirement qualifiers for minstret
//   hpm_event                 - per-counter event strobes for hpmcounter3..
module csr_perf_counters #(
    parameter int NUM_HPM   = 4,
    parameter int CNT_WIDTH = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   csr_en,
    input  logic [11:0]                            csr_addr,
    input  logic [1:0]                             csr_op,
    input  logic [31:0]                            csr_wdata,
    output logic [31:0]                            csr_rdata,
    output logic                                   csr_illegal,
    input  logic                                   retire_valid,
    input  logic                                   stall,
    input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event
);
    // Counter slots: 0 = cycle, 1 = instret, 2+k = hpmcounter(3+k).
    localparam int          NUM_CNT  = NUM_HPM + 2;
    localparam logic [5:0]  HPM_END  = 6'(NUM_HPM + 3);
    localparam logic [31:0] INH_MASK = 32'((64'(1) << (NUM_HPM + 3)) - 64'(1)) & ~32'h2;

    logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt;
    logic [NUM_CNT-1:0]                inc;
    logic [31:0]                       inh, cur, wval;
    logic [4:0]                        num, idx;
    logic                              cnt_hit, inh_hit, is_ro, hi, wr_req, wr_en;

    always_comb begin
        num     = csr_addr[4:0];
        hi      = csr_addr[7];
        is_ro   = csr_addr[11:8] == 4'hC;
        cnt_hit = (is_ro || csr_addr[11:8] == 4'hB) && csr_addr[6:5] == 2'b00 &&
                  (num == 5'd0 || num == 5'd2 || (num >= 5'd3 && {1'b0, num} < HPM_END));
        inh_hit = csr_addr == 12'h320;
        idx     = num == 5'd0 ? 5'd0 : num - 5'd1;
        cur     = '0;
        // Zero-extending to 64 bits makes high-half bits above CNT_WIDTH read as 0.
        for (int i = 0; i < NUM_CNT; i++)
            if (cnt_hit && idx == 5'(i)) cur = hi ? 32'(64'(cnt[i]) >> 32) : cnt[i][31:0];
        if (inh_hit) cur = inh;
        // RS/RC with a zero mask is a pure read: neither a write nor an illegal write.
        wr_req      = csr_en && csr_op != 2'b00 && (csr_op == 2'b01 || csr_wdata != 32'd0);
        wr_en       = wr_req && ((cnt_hit && !is_ro) || inh_hit);
        wval        = csr_op == 2'b01 ? csr_wdata : csr_op == 2'b10 ? cur | csr_wdata : cur & ~csr_wdata;
        csr_rdata   = csr_en ? cur : '0;
        csr_illegal = csr_en && (!(cnt_hit || inh_hit) || (wr_req && cnt_hit && is_ro));
        inc         = '0;
        inc[0]      = !inh[0];
        inc[1]      = retire_valid && !stall && !inh[2];
        for (int k = 0; k < NUM_HPM; k++)
            inc[k+2] = hpm_event[k] && !inh[k+3];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            inh <= '0;
        end else begin
            if (wr_en && inh_hit) inh <= wval & INH_MASK;
            for (int i = 0; i < NUM_CNT; i++) begin
                // Low-half write suppresses the increment; high-half write keeps the
                // low increment but drops its carry.
                if (wr_en && cnt_hit && idx == 5'(i) && !hi)
                    cnt[i] <= {cnt[i][CNT_WIDTH-1:32], wval};
                else if (wr_en && cnt_hit && idx == 5'(i))
                    cnt[i] <= {wval[CNT_WIDTH-33:0], cnt[i][31:0] + 32'(inc[i])};
                else
                    cnt[i] <= cnt[i] + CNT_WIDTH'(inc[i]);
            end
        end
    end
endmodule

// File: tb/tb_csr_perf_counters.sv
// tb_csr_perf_counters: scoreboard bench for csr_perf_counters (64-bit and 40-bit instances)
module tb_csr_perf_counters;
    typedef struct {
        logic        ill;
        logic [31:0] rd;
        logic [31:0] rd40;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_en = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [1:0]  csr_op = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata, rdata40;
    logic        csr_illegal, illegal40;
    logic        retire_valid = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  hpm_event = '0;
    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    csr_perf_counters #(.NUM_HPM(4), .CNT_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .csr_en(csr_en), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .retire_valid(retire_valid), .stall(stall), .hpm_event(hpm_event)
    );

    csr_perf_counters #(.NUM_HPM(4), .CNT_WIDTH(40)) dut40 (
        .clk(clk), .rst_n(rst_n), .csr_en(csr_en), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_rdata(rdata40), .csr_illegal(illegal40),
        .retire_valid(retire_valid), .stall(stall), .hpm_event(hpm_event)
    );

    // Drives one cycle of stimulus at the falling edge and queues the expected read result.
    task automatic step(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eill = 1'b0, input logic chk = 1'b1,
                        input logic en = 1'b1, input logic rv = 1'b0, input logic st = 1'b0,
                        input logic [3:0] ev = 4'd0, input logic [31:0] erd40 = 32'd0);
        @(negedge clk);
        csr_en = en; csr_addr = a; csr_op = op; csr_wdata = wd;
        retire_valid = rv; stall = st; hpm_event = ev;
        if (chk) sb.push_back('{eill, erd, erd40});
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        step(12'hC00, 2'b00, 0, 32'd0);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL reset_read ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(12'hC00, 2'b00, 0, 32'(i));
            e = sb.pop_front(); total++;
            if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL cycle_count_%0d ill=%b rd=%h expected ill=%b rd=%h", i, csr_illegal, csr_rdata, e.ill, e.rd); end
        end
        step(12'hC80, 2'b00, 0, 32'd0);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL cycle_high ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC00, 2'b00, 0, 32'd12);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL pre_reset ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        #2 rst_n = 1'b0;
        sb.push_back('{1'b0, 32'd0, 32'd0});
        #1;
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata, rdata40} !== {e.ill, e.rd, e.rd40}) begin bad++; $display("FAIL async_reset ill=%b rd=%h rd40=%h expected ill=%b rd=%h rd40=%h", csr_illegal, csr_rdata, rdata40, e.ill, e.rd, e.rd40); end
        @(negedge clk);
        rst_n = 1'b1;
        step(12'hC00, 2'b00, 0, 32'd1);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL restart_cycle ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'h320, 2'b00, 0, 32'd0);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL reset_inhibit ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC02, 2'b00, 0, 32'd0);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL reset_instret ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
    endtask

    task automatic test_mcycle_carry;
        exp_t e;
        step(12'hB00, 2'b01, 32'hFFFF_FFFF, 32'd4);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL mcycle_old ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hB00, 2'b00, 0, 32'hFFFF_FFFF);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL mcycle_written ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC00, 2'b00, 0, 32'd0);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL carry_low ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC80, 2'b00, 0, 32'd1);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL carry_high ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
    endtask

    task automatic test_minstret;
        exp_t e;
        logic [1:0] pulses [5] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
        for (int i = 0; i < 5; i++) begin
            step(12'hC02, 2'b00, 0, 32'd0, 1'b0, 1'b1, 1'b0, pulses[i][1], pulses[i][0]);
            e = sb.pop_front(); total++;
            if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL idle_read_%0d ill=%b rd=%h expected ill=%b rd=%h", i, csr_illegal, csr_rdata, e.ill, e.rd); end
        end
        step(12'hC02, 2'b00, 0, 32'd3);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL instret_stall ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'h320, 2'b10, 32'h4, 32'd0);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL inhibit_rs ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'h320, 2'b00, 0, 32'h4);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL inhibit_read ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hB00, 2'b01, 32'd0, 32'd0, 1'b0, 1'b0);
        step(12'hC00, 2'b00, 0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL cycle_zeroed ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC02, 2'b00, 0, 32'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL instret_inhibited_a ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC00, 2'b00, 0, 32'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL cycle_runs ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC02, 2'b00, 0, 32'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL instret_inhibited_b ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC02, 2'b00, 0, 32'd3);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL instret_inhibited_c ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'h320, 2'b11, 32'h4, 32'h4);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL inhibit_rc ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
    endtask

    task automatic test_inhibit_mask;
        exp_t e;
        step(12'h320, 2'b01, 32'hFFFF_FFFF, 32'd0);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL inhibit_cleared ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'h320, 2'b00, 0, 32'h7D);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL inhibit_mask ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'h320, 2'b01, 32'd0, 32'h7D);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL inhibit_restore ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
    endtask

    task automatic test_hpm;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            step(12'hC05, 2'b00, 0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100);
            e = sb.pop_front(); total++;
            if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL hpm_idle_%0d ill=%b rd=%h expected ill=%b rd=%h", i, csr_illegal, csr_rdata, e.ill, e.rd); end
        end
        step(12'hC05, 2'b00, 0, 32'd7);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL hpm5_count ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC03, 2'b00, 0, 32'd0);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL hpm3_quiet ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hB05, 2'b00, 0, 32'd7);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL mhpm5_alias ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC86, 2'b00, 0, 32'd0);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL hpm6_high ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC07, 2'b00, 0, 32'd0, 1'b1);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL hpm7_unmapped ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC01, 2'b00, 0, 32'd0, 1'b1);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL time_unmapped ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'h320, 2'b01, 32'h20, 32'd0);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL hpm_inhibit_set ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        for (int i = 0; i < 3; i++)
            step(12'hC05, 2'b00, 0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101);
        step(12'hC05, 2'b00, 0, 32'd7);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL hpm5_inhibited ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC03, 2'b00, 0, 32'd3);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL hpm3_counts ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'h320, 2'b01, 32'd0, 32'h20);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL hpm_inhibit_clear ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
    endtask

    task automatic test_illegal;
        exp_t e;
        step(12'hB00, 2'b01, 32'd100, 32'd0, 1'b0, 1'b0);
        step(12'hC00, 2'b01, 32'd5, 32'd100, 1'b1);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL ro_write ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC00, 2'b10, 32'd0, 32'd101);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL ro_rs_zero ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC00, 2'b11, 32'd0, 32'd102);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL ro_rc_zero ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC00, 2'b10, 32'd1, 32'd103, 1'b1);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL ro_rs_nonzero ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'h7FF, 2'b00, 0, 32'd0, 1'b0, 1'b1, 1'b0);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL idle_unmapped ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hB02, 2'b11, 32'd1, 32'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL minstret_rc ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC02, 2'b00, 0, 32'd2);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL write_beats_retire ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [1:0]  ops [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        logic [31:0] wds [4] = '{32'h0F, 32'hF0, 32'h3C, 32'h0};
        logic [31:0] rds [4] = '{32'd3, 32'h0F, 32'hFF, 32'hC3};
        for (int i = 0; i < 4; i++) begin
            step(12'hB03, ops[i], wds[i], rds[i]);
            e = sb.pop_front(); total++;
            if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL rmw_%0d ill=%b rd=%h expected ill=%b rd=%h", i, csr_illegal, csr_rdata, e.ill, e.rd); end
        end
    endtask

    task automatic test_high_write;
        exp_t e;
        step(12'hB00, 2'b01, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        step(12'hB80, 2'b01, 32'h10, 32'd0, 1'b0, 1'b0);
        step(12'hC80, 2'b00, 0, 32'h10);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL high_write_nocarry ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC00, 2'b00, 0, 32'd1);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL high_write_low ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hB00, 2'b01, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        step(12'hB00, 2'b01, 32'd7, 32'hFFFF_FFFF);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL low_write_old ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC80, 2'b00, 0, 32'h10);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL low_write_nocarry ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
        step(12'hC00, 2'b00, 0, 32'd8);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata} !== {e.ill, e.rd}) begin bad++; $display("FAIL low_write_value ill=%b rd=%h expected ill=%b rd=%h", csr_illegal, csr_rdata, e.ill, e.rd); end
    endtask

    task automatic test_width40;
        exp_t e;
        step(12'hB80, 2'b01, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        step(12'hC80, 2'b00, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0000_00FF);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata, illegal40, rdata40} !== {e.ill, e.rd, e.ill, e.rd40}) begin bad++; $display("FAIL w40_high_trunc ill=%b rd=%h ill40=%b rd40=%h expected ill=%b rd=%h rd40=%h", csr_illegal, csr_rdata, illegal40, rdata40, e.ill, e.rd, e.rd40); end
        step(12'hB00, 2'b01, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        step(12'hC00, 2'b00, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'hFFFF_FFFF);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata, illegal40, rdata40} !== {e.ill, e.rd, e.ill, e.rd40}) begin bad++; $display("FAIL w40_max ill=%b rd=%h ill40=%b rd40=%h expected ill=%b rd=%h rd40=%h", csr_illegal, csr_rdata, illegal40, rdata40, e.ill, e.rd, e.rd40); end
        step(12'hC80, 2'b00, 0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata, illegal40, rdata40} !== {e.ill, e.rd, e.ill, e.rd40}) begin bad++; $display("FAIL w40_wrap_high ill=%b rd=%h ill40=%b rd40=%h expected ill=%b rd=%h rd40=%h", csr_illegal, csr_rdata, illegal40, rdata40, e.ill, e.rd, e.rd40); end
        step(12'hC00, 2'b00, 0, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'd1);
        e = sb.pop_front(); total++;
        if ({csr_illegal, csr_rdata, illegal40, rdata40} !== {e.ill, e.rd, e.ill, e.rd40}) begin bad++; $display("FAIL w40_wrap_low ill=%b rd=%h ill40=%b rd40=%h expected ill=%b rd=%h rd40=%h", csr_illegal, csr_rdata, illegal40, rdata40, e.ill, e.rd, e.rd40); end
    endtask

    initial begin
        test_reset;
        test_mcycle_carry;
        test_minstret;
        test_inhibit_mask;
        test_hpm;
        test_illegal;
        test_back_to_back;
        test_high_write;
        test_width40;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
